dx_latch: RTL
=============

// Module: dx_latch
// PURPOSE
//   Decode/execute pipeline register for the 5-stage core. Captures the decoded instruction
//   and its PC once per cycle and presents registered OP/ALUOP fields to the control minterm
//   decoders (e.g. sig_or). It also presents the rd/rs/rt/shamt/imm fields to the execute stage.
//   It handles stall and flush, and detects load-use hazards, inserting one bubble and
//   requesting an upstream hold.
// PARAMETERS
//   LW_OP    5'b01000  opcode treated as a load for hazard detection
//   PC_W     32        width of program counter
// PORTS
//   clock      in   1     rising-edge clock
//   reset      in   1     synchronous, active-high reset
//   in_valid   in   1     F/D stage holds a real instruction
//   in_insn    in   32    F/D instruction word
//   in_pc      in   PC_W  F/D PC
//   stall_in   in   1     external hold (multdiv busy); freezes this register
//   flush      in   1     branch/jump taken in X; squashes current D instruction
//   out_valid  out  1     D/X holds a real instruction
//   out_insn   out  32    registered instruction (NOP = 32'h0 when bubble)
//   out_pc     out  PC_W  registered PC
//   OP         out  5     out_insn[31:27]
//   ALUOP      out  5     out_insn[6:2]
//   rd/rs/rt   out  5     out_insn[26:22] / [21:17] / [16:12]
//   shamt      out  5     out_insn[11:7]
//   imm        out  32    out_insn[16:0] sign-extended to 32 bits
//   stall_out  out  1     load-use hazard; F/D and PC must hold this cycle
// BEHAVIOUR
// - Reset: out_valid=0, out_insn=0, out_pc=0; all field outputs are therefore 0 and stall_out=0.
// - All field outputs are pure slices of registered out_insn; no added latency.
// - Latency is one cycle from F/D to D/X.
// - hazard (combinational) = out_valid & in_valid & OP==LW_OP & rd!=0
//     & (rd==in_insn[21:17] | (in_insn[31:27]==5'b00000 & rd==in_insn[16:12])).
// - stall_out = hazard & ~flush & ~stall_in.
// - Per-edge update, priority high->low:
//     1 reset     -> reset values
//     2 flush     -> bubble: out_valid=0, out_insn=0, out_pc unchanged. Flush wins over stall_in.
//     3 stall_in  -> hold all registers
//     4 hazard    -> bubble (as flush) and stall_out=1; upstream re-presents the same insn next cycle
//     5 otherwise -> out_valid<=in_valid, out_insn<=in_valid?in_insn:0, out_pc<=in_pc
// - A bubble is never a load, so a hazard cannot persist beyond one cycle for the same pair.
// - An invalid input (in_valid=0) loads as a bubble; register $0 destination never raises a hazard.
// - Reset mid-stall/mid-hazard discards the held instruction; stall_out drops on the same edge.
// TESTING
// - Reset: assert reset 2 cycles with in_insn=32'hFFFF_FFFF -> out_valid=0, OP=0, ALUOP=0, stall_out=0.
// - Pass-through: in_insn=32'h0062_200C (R-type, ALUOP=00011), in_pc=4
//     -> next cycle OP=00000, ALUOP=00011, rd=1, rs=17, rt=2, out_pc=4.
// - Load-use: D/X holds lw rd=3 (insn 32'h40C0_0000); input add with rs=3
//     -> stall_out=1; next edge out_insn=0, out_valid=0; following edge the add loads.
// - No hazard on $0: D/X holds lw rd=0, input rs=0 -> stall_out=0, instruction loads.
// - Flush over stall: flush=1 and stall_in=1 together -> out_valid=0, out_insn=0 next cycle.
// - Stall hold: stall_in=1 for 3 cycles while in_insn changes -> outputs constant; stall_out=0.

Source files
------------

// File: rtl/dx_latch.sv
// Decode/execute pipeline register with stall, flush and load-use hazard detection.
// Holds the decoded instruction and its PC for the execute stage, exposes the
// opcode/register/immediate fields as slices of the registered word, and asks
// the upstream stages to hold for one cycle when a load feeds the next instruction.
module dx_latch #(
    parameter logic [4:0]  LW_OP = 5'b01000,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    input  logic            stall_in,
    input  logic            flush,
    output logic            out_valid,
    output logic [31:0]     out_insn,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      OP,
    output logic [4:0]      ALUOP,
    output logic [4:0]      rd,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      shamt,
    output logic [31:0]     imm,
    output logic            stall_out
);

    localparam int unsigned INSN_W = 32;
    localparam int unsigned IMM_W  = 17;

    logic [4:0] in_op;
    logic [4:0] in_rs;
    logic [4:0] in_rt;
    logic       rd_match;
    logic       hazard;

    // Field slices of the registered instruction; no extra pipeline delay.
    assign OP    = out_insn[31:27];
    assign rd    = out_insn[26:22];
    assign rs    = out_insn[21:17];
    assign rt    = out_insn[16:12];
    assign shamt = out_insn[11:7];
    assign ALUOP = out_insn[6:2];
    assign imm   = {{(INSN_W - IMM_W){out_insn[IMM_W-1]}}, out_insn[IMM_W-1:0]};

    // Source fields of the incoming instruction; rt is only a source for R-type.
    assign in_op = in_insn[31:27];
    assign in_rs = in_insn[21:17];
    assign in_rt = in_insn[16:12];

    // Load-use hazard: the load in D/X writes a register the incoming insn reads.
    always_comb begin
        rd_match = 1'b0;
        hazard   = 1'b0;
        rd_match = (rd == in_rs) || ((in_op == 5'b00000) && (rd == in_rt));
        hazard   = out_valid && in_valid && (OP == LW_OP) && (rd != 5'd0) && rd_match;
    end

    // Upstream hold is only meaningful when this register would otherwise advance.
    assign stall_out = hazard && !flush && !stall_in;

    // Pipeline register update: reset, flush bubble, hold, hazard bubble, advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_insn  <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_insn  <= '0;
        end else if (stall_in) begin
            out_valid <= out_valid;
            out_insn  <= out_insn;
            out_pc    <= out_pc;
        end else if (hazard) begin
            out_valid <= 1'b0;
            out_insn  <= '0;
        end else begin
            out_valid <= in_valid;
            out_insn  <= in_valid ? in_insn : '0;
            out_pc    <= in_pc;
        end
    end

endmodule
